// File: rtl/onewire_pkg.sv
// Shared constants for the 1-Wire responder: FSM encodings, default slot timing
// in 7.5 us ticks, and the width of the saturating low-width counter.
package onewire_pkg;

    localparam int DVN_DFLT   = 180;
    localparam int RST_T_DFLT = 48;
    localparam int SMP_T_DFLT = 4;
    localparam int PDH_T_DFLT = 4;
    localparam int PDL_T_DFLT = 16;

    localparam int               CNT_W   = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_SLOT     = 3'd1;
    localparam state_t ST_RST_WAIT = 3'd2;
    localparam state_t ST_PRES_DLY = 3'd3;
    localparam state_t ST_PRES_DRV = 3'd4;

endpackage

// File: rtl/onewire_slave_tick.sv
// Slot-aligned timebase: DVN-cycle divider producing a tick pulse, plus a
// saturating count of ticks since the last restart.
module onewire_slave_tick
    import onewire_pkg::*;
#(
    parameter int DVN = DVN_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    output logic             tick,
    output logic             half,
    output logic [CNT_W-1:0] width
);

    localparam int               DIV_W    = (DVN > 1) ? $clog2(DVN) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DVN - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DVN / 2);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_LAST);
    assign half = (div >= DIV_HALF);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div   <= '0;
            width <= '0;
        end else if (restart) begin
            div   <= '0;
            width <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick && width != CNT_MAX) begin
                width <= width + 1'b1;
            end
        end
    end

endmodule

// File: rtl/onewire_slave.sv
// 1-Wire device end: reset/presence handshake, write-slot sampling into rx
// bytes and read-slot answering from a locally offered tx byte.
module onewire_slave
    import onewire_pkg::*;
#(
    parameter int DVN   = DVN_DFLT,
    parameter int RST_T = RST_T_DFLT,
    parameter int SMP_T = SMP_T_DFLT,
    parameter int PDH_T = PDH_T_DFLT,
    parameter int PDL_T = PDL_T_DFLT
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        onewire,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       reset_det,
    output logic       busy
);

    localparam logic [CNT_W-1:0] SMP_HIT = CNT_W'(SMP_T - 1);
    localparam logic [CNT_W-1:0] RST_HIT = CNT_W'(RST_T - 1);
    localparam logic [CNT_W-1:0] PDH_HIT = CNT_W'(PDH_T - 1);
    localparam logic [CNT_W-1:0] PDL_HIT = CNT_W'(PDL_T - 1);

    state_t           state;
    logic [1:0]       bus_sync;
    logic             bus_now;
    logic             bus_prev;
    logic             fall;
    logic             rise;
    logic             drive;
    logic             sampled;
    logic [2:0]       bit_cnt;
    logic [7:0]       rx_shift;
    logic [7:0]       tx_shift;
    logic             tx_pending;
    logic             accept;
    logic             restart;
    logic             tick;
    logic             half;
    logic [CNT_W-1:0] width;
    logic             glitch;
    logic             sample_hit;
    logic             reset_hit;
    logic             pdh_hit;
    logic             pdl_hit;

    assign onewire = drive ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_sync <= 2'b11;
        end else begin
            bus_sync <= {bus_sync[0], onewire};
        end
    end

    assign bus_now  = bus_sync[0];
    assign bus_prev = bus_sync[1];
    assign fall     = bus_prev & ~bus_now;
    assign rise     = ~bus_prev & bus_now;

    // A low shorter than half a tick is noise, not a slot.
    assign glitch     = rise && (width == '0) && !half;
    assign sample_hit = tick && (width == SMP_HIT) && !sampled;
    assign reset_hit  = tick && (width == RST_HIT);
    assign pdh_hit    = tick && (width == PDH_HIT);
    assign pdl_hit    = tick && (width == PDL_HIT);

    assign tx_ready = (state == ST_IDLE) && !tx_pending && (bit_cnt == 3'd0);
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state != ST_IDLE);

    // NOTE: restart gets its default first so no path through the case leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        restart = 1'b0;
        case (state)
            ST_IDLE:     restart = fall;
            ST_SLOT:     restart = fall;
            ST_RST_WAIT: restart = rise;
            ST_PRES_DLY: restart = fall | pdh_hit;
            default:     restart = 1'b0;
        endcase
    end

    onewire_slave_tick #(
        .DVN(DVN)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick),
        .half   (half),
        .width  (width)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            drive      <= 1'b0;
            sampled    <= 1'b0;
            bit_cnt    <= 3'd0;
            rx_shift   <= 8'h00;
            tx_shift   <= 8'h00;
            tx_pending <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            reset_det  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            reset_det <= 1'b0;

            if (accept) begin
                tx_shift   <= tx_data;
                tx_pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state   <= ST_SLOT;
                        sampled <= 1'b0;
                        // A byte accepted on this very edge already owns the slot.
                        drive   <= tx_pending ? ~tx_shift[0] : (accept & ~tx_data[0]);
                    end
                end

                ST_SLOT: begin
                    if (reset_hit && !bus_now) begin
                        state      <= ST_RST_WAIT;
                        drive      <= 1'b0;
                        bit_cnt    <= 3'd0;
                        rx_shift   <= 8'h00;
                        tx_pending <= 1'b0;
                    end else if (sample_hit) begin
                        sampled <= 1'b1;
                        drive   <= 1'b0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (tx_pending) begin
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            if (bit_cnt == 3'd7) begin
                                tx_pending <= 1'b0;
                            end
                        end else begin
                            rx_shift <= {bus_now, rx_shift[7:1]};
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= {bus_now, rx_shift[7:1]};
                                rx_valid <= 1'b1;
                            end
                        end
                    end else if (sampled ? bus_now : glitch) begin
                        state <= ST_IDLE;
                        drive <= 1'b0;
                    end
                end

                ST_RST_WAIT: begin
                    if (rise) begin
                        reset_det <= 1'b1;
                        state     <= ST_PRES_DLY;
                    end
                end

                ST_PRES_DLY: begin
                    if (pdh_hit) begin
                        state <= ST_PRES_DRV;
                        drive <= 1'b1;
                    end
                end

                ST_PRES_DRV: begin
                    if (pdl_hit) begin
                        state <= ST_IDLE;
                        drive <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    drive <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_slave.sv
// Directed bench for onewire_slave: a bus master model with a pullup, slot
// timing in clock cycles at DVN=12 (one 7.5 us tick = 12 cycles).
module tb_onewire_slave;

    localparam int DVN    = 12;
    localparam int T_W1   = 10;   // 6 us write-1 / read low
    localparam int T_W0   = 96;   // 60 us write-0 low
    localparam int T_SLOT = 120;
    localparam int T_RDS  = 21;   // 13 us read sample point
    localparam int T_RST  = 768;  // 480 us reset low
    localparam int T_GL   = 3;    // 2 us glitch

    logic       clk = 1'b0;
    logic       rst;
    logic       m_low;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic       reset_det;
    logic       busy;
    wire        onewire;

    int n_vec = 0;
    int n_err = 0;

    int         rxv_cnt   = 0;
    int         rdet_cnt  = 0;
    int         overlap   = 0;
    int         slave_drv = 0;
    logic       mon_drv   = 1'b0;
    logic [7:0] rx_last   = 8'h00;

    always #5 clk = ~clk;

    assign onewire = m_low ? 1'b0 : 1'bz;
    pullup (onewire);

    onewire_slave #(
        .DVN(DVN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .onewire  (onewire),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .reset_det(reset_det),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt = rxv_cnt + 1;
            rx_last = rx_data;
        end
        if (reset_det) rdet_cnt = rdet_cnt + 1;
        if (rx_valid && reset_det) overlap = overlap + 1;
        if (mon_drv && !m_low && onewire !== 1'b1) slave_drv = slave_drv + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_bit(input logic b);
        int lo;
        lo    = b ? T_W1 : T_W0;
        m_low = 1'b1;
        cyc(lo);
        m_low = 1'b0;
        cyc(T_SLOT - lo);
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
    endtask

    task automatic read_byte(output logic [7:0] v);
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_low = 1'b1;
            cyc(T_W1);
            m_low = 1'b0;
            cyc(T_RDS - T_W1);
            v[i] = onewire;
            cyc(T_SLOT - T_RDS);
        end
    endtask

    task automatic bus_reset();
        m_low = 1'b1;
        cyc(T_RST);
        m_low = 1'b0;
    endtask

    // Call right after the master releases a reset; times counted in cycles.
    task automatic watch_presence(output int st, output int en, output int busy_bad);
        st = -1;
        en = -1;
        busy_bad = 0;
        for (int k = 1; k <= 300; k++) begin
            cyc(1);
            if (onewire === 1'b0) begin
                if (st < 0) st = k;
                if (!busy) busy_bad++;
            end else if (st >= 0 && en < 0) begin
                en = k;
            end
        end
    endtask

    initial begin
        int         st, en, bb;
        int         v0, r0, d0;
        logic [7:0] rd;

        rst      = 1'b0;
        m_low    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        cyc(3);
        check("rst_rx_data",   rx_data,   8'h00);
        check("rst_rx_valid",  rx_valid,  1'b0);
        check("rst_tx_ready",  tx_ready,  1'b1);
        check("rst_reset_det", reset_det, 1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_line",      onewire,   1'b1);
        rst = 1'b1;
        cyc(5);

        // Presence: 30 us .. 150 us after the rise, +/- 1 tick plus sync latency.
        r0 = rdet_cnt;
        bus_reset();
        watch_presence(st, en, bb);
        check("pres_reset_det_pulses", rdet_cnt - r0, 1);
        check($sformatf("pres_start(%0d)", st), (st >= 36 && st <= 63), 1'b1);
        check($sformatf("pres_end(%0d)", en), (en >= 228 && en <= 255), 1'b1);
        check("pres_busy_while_low", bb, 0);
        check("pres_busy_after", busy, 1'b0);

        // Write 0xA5.
        v0 = rxv_cnt;
        d0 = slave_drv;
        mon_drv = 1'b1;
        write_byte(8'hA5);
        mon_drv = 1'b0;
        check("wr_a5_pulses", rxv_cnt - v0, 1);
        check("wr_a5_data", rx_last, 8'hA5);
        check("wr_a5_slave_drive", slave_drv - d0, 0);

        // Read 0x3C.
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        check("rd_tx_ready_pre", tx_ready, 1'b1);
        cyc(1);
        tx_valid = 1'b0;
        check("rd_tx_ready_post", tx_ready, 1'b0);
        v0 = rxv_cnt;
        read_byte(rd);
        check("rd_3c_bits", rd, 8'h3C);
        check("rd_3c_no_rx", rxv_cnt - v0, 0);
        check("rd_3c_tx_ready_end", tx_ready, 1'b1);

        // Reset after three write slots discards the partial byte.
        v0 = rxv_cnt;
        r0 = rdet_cnt;
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        bus_reset();
        watch_presence(st, en, bb);
        check("mid_no_rx", rxv_cnt - v0, 0);
        check("mid_reset_det", rdet_cnt - r0, 1);
        check($sformatf("mid_pres_start(%0d)", st), (st >= 36 && st <= 63), 1'b1);
        write_byte(8'h01);
        check("mid_wr01_pulses", rxv_cnt - v0, 1);
        check("mid_wr01_data", rx_last, 8'h01);

        // Glitches neither start a bit nor disturb a byte in progress.
        m_low = 1'b1;
        cyc(T_GL);
        m_low = 1'b0;
        cyc(20);
        check("gl_idle_tx_ready", tx_ready, 1'b1);
        check("gl_idle_busy", busy, 1'b0);
        v0 = rxv_cnt;
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        m_low = 1'b1;
        cyc(T_GL);
        m_low = 1'b0;
        cyc(20);
        for (int i = 0; i < 4; i++) write_bit(1'b0);
        check("gl_byte_pulses", rxv_cnt - v0, 1);
        check("gl_byte_data", rx_last, 8'h0F);

        // Reset asserted while the presence pulse is being driven.
        bus_reset();
        cyc(100);
        check("abort_pres_active", onewire, 1'b0);
        rst = 1'b0;
        #1;
        check("abort_line", onewire, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_tx_ready", tx_ready, 1'b1);
        check("abort_rx_valid", rx_valid, 1'b0);
        check("abort_reset_det", reset_det, 1'b0);
        check("abort_rx_data", rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        cyc(5);

        // Back-to-back: tx 0xFF straight into an rx write of 0x00.
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        v0 = rxv_cnt;
        read_byte(rd);
        check("b2b_rd_ff", rd, 8'hFF);
        write_byte(8'h00);
        check("b2b_wr_pulses", rxv_cnt - v0, 1);
        check("b2b_wr_data", rx_last, 8'h00);

        check("rxv_rstdet_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
